// File: rtl/i_fetch_pkg.sv
// Shared fetch-stage definitions: instruction width, PC step, NOP encoding
// and the IF/ID pipeline latch layout.
package i_fetch_pkg;

  localparam int          INSTR_W   = 32;
  localparam logic [31:0] PC_STEP   = 32'd4;
  // sll $0,$0,0 encodes as all zeros; used for bubbles and unloaded ROM words.
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instruction;
    logic [31:0]        npc;
    logic               valid;
  } if_id_t;

  // Contents of IF/ID after reset or a branch flush.
  localparam if_id_t IF_ID_BUBBLE = '{instruction: NOP_INSTR, npc: 32'h0, valid: 1'b0};

endpackage

// File: rtl/i_fetch_inst_mem.sv
// Instruction ROM with asynchronous read. The image is fixed at elaboration
// through ROM_IMAGE (word i at bits [32*i +: 32]); words not given read as 0,
// which decodes as a NOP, so no X ever leaves the ROM.
module inst_mem
  import i_fetch_pkg::*;
#(
  parameter int                             MEM_DEPTH = 128,
  parameter logic [MEM_DEPTH*INSTR_W-1:0]   ROM_IMAGE = '0
) (
  input  logic [$clog2(MEM_DEPTH)-1:0] addr,
  output logic [INSTR_W-1:0]           data
);

  localparam int AW = $clog2(MEM_DEPTH);

  // Bit offset of the addressed word inside the flat image (addr * 32).
  logic [AW+4:0] base;
  assign base = {addr, 5'd0};
  assign data = ROM_IMAGE[base +: INSTR_W];

endmodule

// File: rtl/i_fetch.sv
// Instruction-fetch stage: PC register, PC+4 incrementer, branch-target mux,
// instruction ROM and the IF/ID pipeline latch feeding i_decode.
// Priority at each clock edge: reset > redirect > stall > normal fetch.
module i_fetch
  import i_fetch_pkg::*;
#(
  parameter logic [31:0]                  RESET_PC  = 32'h0000_0000,
  parameter int                           MEM_DEPTH = 128,
  parameter logic [MEM_DEPTH*INSTR_W-1:0] ROM_IMAGE = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                EX_MEM_pcsrc,
  input  logic [31:0]         EX_MEM_npc,
  input  logic                stall,
  output logic [INSTR_W-1:0]  IF_ID_instruction,
  output logic [31:0]         IF_ID_npc,
  output logic                IF_ID_valid,
  output logic [31:0]         pc_out
);

  localparam int AW = $clog2(MEM_DEPTH);

  logic [31:0]        pc;
  logic [31:0]        pc_next;
  logic [31:0]        npc;
  logic [INSTR_W-1:0] rom_data;
  if_id_t             if_id;

  // Branch targets are forced word-aligned, so their low bits never matter.
  logic unused_target_low;
  assign unused_target_low = ^EX_MEM_npc[1:0];

  // Wraps modulo 2^32 naturally.
  assign npc = pc + PC_STEP;

  // Upper PC bits are dropped, so the fetch index wraps modulo MEM_DEPTH.
  inst_mem #(
    .MEM_DEPTH (MEM_DEPTH),
    .ROM_IMAGE (ROM_IMAGE)
  ) u_rom (
    .addr (pc[AW+1:2]),
    .data (rom_data)
  );

  // Next-PC select: redirect beats stall, stall holds, otherwise advance.
  always_comb begin
    // NOTE: default assigned first so every path drives pc_next and no latch is inferred.
    pc_next = pc;
    if (EX_MEM_pcsrc) begin
      pc_next = {EX_MEM_npc[31:2], 2'b00};
    end else if (!stall) begin
      pc_next = npc;
    end
  end

  // PC register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so all registers sample pre-edge values.
    if (!rst_n) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

  // IF/ID latch: reset and redirect insert a bubble, stall holds, normal loads the fetch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if_id <= IF_ID_BUBBLE;
    end else if (EX_MEM_pcsrc) begin
      if_id <= IF_ID_BUBBLE;
    end else if (!stall) begin
      if_id <= '{instruction: rom_data, npc: npc, valid: 1'b1};
    end
  end

  assign IF_ID_instruction = if_id.instruction;
  assign IF_ID_npc         = if_id.npc;
  assign IF_ID_valid       = if_id.valid;
  assign pc_out            = pc;

endmodule

// File: tb/tb_i_fetch.sv
// Directed bench for i_fetch: each step drives inputs, pushes its expected
// post-edge state onto a scoreboard, then pops and compares after the edge.
module tb_i_fetch;
  import i_fetch_pkg::*;

  localparam int DEPTH = 128;

  // Known ROM image: words 0..31 and 127 carry distinct non-zero patterns,
  // every other word stays 0.
  function automatic logic [31:0] rom_word(input int i);
    logic [31:0] w;
    w = 32'h0;
    if (i < 32 || i == 127) w = 32'h2000_0000 + 32'(i) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [DEPTH*32-1:0] build_image();
    logic [DEPTH*32-1:0] img;
    img = '0;
    for (int i = 0; i < DEPTH; i++) img[i*32 +: 32] = rom_word(i);
    return img;
  endfunction

  localparam logic [DEPTH*32-1:0] IMAGE = build_image();

  logic        clk = 1'b0;
  logic        rst_n;
  logic        EX_MEM_pcsrc;
  logic [31:0] EX_MEM_npc;
  logic        stall;
  logic [31:0] IF_ID_instruction;
  logic [31:0] IF_ID_npc;
  logic        IF_ID_valid;
  logic [31:0] pc_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] npc;
    logic        v;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];

  i_fetch #(
    .RESET_PC  (32'h0000_0000),
    .MEM_DEPTH (DEPTH),
    .ROM_IMAGE (IMAGE)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .EX_MEM_pcsrc      (EX_MEM_pcsrc),
    .EX_MEM_npc        (EX_MEM_npc),
    .stall             (stall),
    .IF_ID_instruction (IF_ID_instruction),
    .IF_ID_npc         (IF_ID_npc),
    .IF_ID_valid       (IF_ID_valid),
    .pc_out            (pc_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive on the falling edge, compare 1 time unit after the rising edge.
  task automatic step(input logic r, input logic p, input logic s, input logic [31:0] tgt,
                      input logic [31:0] e_pc, input logic [31:0] e_ins,
                      input logic [31:0] e_npc, input logic e_v, input string tag);
    exp_t  e;
    string t;
    @(negedge clk);
    rst_n        = r;
    EX_MEM_pcsrc = p;
    stall        = s;
    EX_MEM_npc   = tgt;
    sb_q.push_back('{pc: e_pc, ins: e_ins, npc: e_npc, v: e_v});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    check({t, ".pc"},    pc_out,            e.pc);
    check({t, ".instr"}, IF_ID_instruction, e.ins);
    check({t, ".npc"},   IF_ID_npc,         e.npc);
    check({t, ".valid"}, {31'd0, IF_ID_valid}, {31'd0, e.v});
  endtask

  initial begin
    rst_n        = 1'b0;
    EX_MEM_pcsrc = 1'b0;
    stall        = 1'b0;
    EX_MEM_npc   = 32'h0;

    // Reset state
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, NOP_INSTR, 32'h0, 1'b0, "reset");

    // Free-running fetch
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h4, rom_word(0), 32'h4, 1'b1, "run0");
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h8, rom_word(1), 32'h8, 1'b1, "run1");

    // Stall holds PC and IF/ID, including over a long hold
    step(1'b1, 1'b0, 1'b1, 32'h0, 32'h8, rom_word(1), 32'h8, 1'b1, "stall0");
    step(1'b1, 1'b0, 1'b1, 32'h0, 32'h8, rom_word(1), 32'h8, 1'b1, "stall1");
    for (int i = 0; i < 6; i++)
      step(1'b1, 1'b0, 1'b1, 32'h0, 32'h8, rom_word(1), 32'h8, 1'b1, "stall_long");
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'hC, rom_word(2), 32'hC, 1'b1, "release");

    // Redirect to 0x40: one bubble, then rom[16]
    step(1'b1, 1'b1, 1'b0, 32'h40, 32'h40, NOP_INSTR, 32'h0, 1'b0, "redir");
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h44, rom_word(16), 32'h44, 1'b1, "redir_fetch");

    // Redirect together with stall: redirect wins; unloaded word reads as NOP
    step(1'b1, 1'b1, 1'b1, 32'h80, 32'h80, NOP_INSTR, 32'h0, 1'b0, "redir_stall");
    step(1'b1, 1'b1 ^ 1'b1, 1'b1, 32'h0, 32'h80, NOP_INSTR, 32'h0, 1'b0, "bubble_hold");
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h84, 32'h0, 32'h84, 1'b1, "empty_word");

    // Misaligned target is word-aligned
    step(1'b1, 1'b1, 1'b0, 32'h43, 32'h40, NOP_INSTR, 32'h0, 1'b0, "misalign");
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h44, rom_word(16), 32'h44, 1'b1, "misalign_fetch");

    // Index wrap: target 4*DEPTH+8 fetches rom[2]
    step(1'b1, 1'b1, 1'b0, 32'h208, 32'h208, NOP_INSTR, 32'h0, 1'b0, "wrap_redir");
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h20C, rom_word(2), 32'h20C, 1'b1, "wrap_fetch");

    // PC+4 wraps to 0 from the top of the address space
    step(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, NOP_INSTR, 32'h0, 1'b0, "top_redir");
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, rom_word(127), 32'h0, 1'b1, "top_wrap");

    // Reset mid-stream overrides stall and redirect
    step(1'b1, 1'b1, 1'b0, 32'h20, 32'h20, NOP_INSTR, 32'h0, 1'b0, "pre_rst");
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h24, rom_word(8), 32'h24, 1'b1, "pre_rst_fetch");
    step(1'b0, 1'b1, 1'b1, 32'h80, 32'h0, NOP_INSTR, 32'h0, 1'b0, "mid_rst");
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h4, rom_word(0), 32'h4, 1'b1, "post_rst");
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h8, rom_word(1), 32'h8, 1'b1, "post_rst2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
